// File: rtl/microwave_ctrl.sv
// Microwave oven controller: keypad entry of a four-digit BCD cook time,
// start/pause/resume/clear handling, magnetron drive, and a completion beep
// that lasts three 1 Hz ticks. The countdown itself lives in an external timer.
module microwave_ctrl (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clr,
  input  logic        door_closed,
  input  logic        tick,
  input  logic        timer_zero,
  output logic [15:0] timer_data,
  output logic        timer_loadn,
  output logic        timer_clrn,
  output logic        timer_en,
  output logic        mag_on,
  output logic        beep,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] entry;
  logic [1:0]  tick_cnt;

  logic        key_ok;
  logic        entry_nz;
  logic [15:0] shifted;

  // Keypad qualification and the shifted entry value a new digit would produce
  always_comb begin
    key_ok   = key_valid && (key_digit <= 4'd9);
    entry_nz = |entry;
    shifted  = {entry[11:0], key_digit};
  end

  // Control FSM; the timer load/clear strobes are one-cycle registered pulses
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      entry       <= 16'h0000;
      tick_cnt    <= 2'd0;
      timer_loadn <= 1'b1;
      timer_clrn  <= 1'b1;
    end else begin
      timer_loadn <= 1'b1;
      timer_clrn  <= 1'b1;
      case (state)
        IDLE: begin
          if (key_ok) begin
            entry <= shifted;
            state <= ENTRY;
          end
        end
        ENTRY: begin
          if (stop_clr) begin
            entry      <= 16'h0000;
            timer_clrn <= 1'b0;
            state      <= IDLE;
          end else if (start && door_closed && entry_nz) begin
            timer_loadn <= 1'b0;
            state       <= COOK;
          end else if (key_ok) begin
            entry <= shifted;
          end
        end
        COOK: begin
          // timer_zero is stale while the load strobe is low, so it is masked then
          if (!door_closed || stop_clr) begin
            state <= PAUSE;
          end else if (timer_zero && timer_loadn) begin
            tick_cnt <= 2'd0;
            state    <= DONE;
          end
        end
        PAUSE: begin
          if (stop_clr) begin
            entry      <= 16'h0000;
            timer_clrn <= 1'b0;
            state      <= IDLE;
          end else if (start && door_closed) begin
            state <= COOK;
          end
        end
        DONE: begin
          if (stop_clr) begin
            entry    <= 16'h0000;
            tick_cnt <= 2'd0;
            state    <= IDLE;
          end else if (tick) begin
            if (tick_cnt == 2'd2) begin
              entry    <= 16'h0000;
              tick_cnt <= 2'd0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 2'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs that must react within the current cycle to door and tick inputs
  always_comb begin
    timer_data = entry;
    state_o    = state;
    timer_en   = (state == COOK) && tick && door_closed && !timer_zero;
    mag_on     = (state == COOK) && door_closed;
    beep       = (state == DONE);
  end

endmodule

// File: tb/tb_microwave_ctrl.sv
// Bench for microwave_ctrl: directed stimulus, a spec-level model of the
// controller compared on every falling edge, plus hand-computed spot checks.
module tb_microwave_ctrl;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start = 1'b0;
  logic        stop_clr = 1'b0;
  logic        door_closed = 1'b1;
  logic        tick = 1'b0;
  logic        timer_zero = 1'b0;
  logic [15:0] timer_data;
  logic        timer_loadn;
  logic        timer_clrn;
  logic        timer_en;
  logic        mag_on;
  logic        beep;
  logic [2:0]  state_o;

  int checks = 0;
  int errors = 0;

  microwave_ctrl dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clr(stop_clr), .door_closed(door_closed),
    .tick(tick), .timer_zero(timer_zero), .timer_data(timer_data),
    .timer_loadn(timer_loadn), .timer_clrn(timer_clrn), .timer_en(timer_en),
    .mag_on(mag_on), .beep(beep), .state_o(state_o)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Model state: mode number as listed in the requirements, digits oldest first
  int mMode = 0;
  int mDig[4] = '{0, 0, 0, 0};
  int mTicksSeen = 0;
  bit mLoadLow = 1'b0;
  bit mClearLow = 1'b0;

  function automatic logic [15:0] packDigits(input int d[4]);
    return 16'(d[0] * 4096 + d[1] * 256 + d[2] * 16 + d[3]);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model step: apply the controller rules to the inputs seen at each rising edge
  always @(posedge clk or negedge clrn) begin
    int nMode;
    int nDig[4];
    int nTicks;
    bit nLoad;
    bit nClear;
    bit keyOk;
    bit nonzero;
    if (!clrn) begin
      mMode <= 0;
      mDig <= '{0, 0, 0, 0};
      mTicksSeen <= 0;
      mLoadLow <= 1'b0;
      mClearLow <= 1'b0;
    end else begin
      nMode = mMode;
      nDig = mDig;
      nTicks = mTicksSeen;
      nLoad = 1'b0;
      nClear = 1'b0;
      keyOk = key_valid && (int'(key_digit) < 10);
      nonzero = (mDig[0] + mDig[1] + mDig[2] + mDig[3]) > 0;
      if (mMode == 0) begin
        if (keyOk) begin
          nDig = '{mDig[1], mDig[2], mDig[3], int'(key_digit)};
          nMode = 1;
        end
      end else if (mMode == 1) begin
        if (stop_clr) begin
          nDig = '{0, 0, 0, 0};
          nClear = 1'b1;
          nMode = 0;
        end else if (start && door_closed && nonzero) begin
          nLoad = 1'b1;
          nMode = 2;
        end else if (keyOk) begin
          nDig = '{mDig[1], mDig[2], mDig[3], int'(key_digit)};
        end
      end else if (mMode == 2) begin
        if (!door_closed || stop_clr) nMode = 3;
        else if (timer_zero && !mLoadLow) begin
          nMode = 4;
          nTicks = 0;
        end
      end else if (mMode == 3) begin
        if (stop_clr) begin
          nDig = '{0, 0, 0, 0};
          nClear = 1'b1;
          nMode = 0;
        end else if (start && door_closed) begin
          nMode = 2;
        end
      end else if (mMode == 4) begin
        if (stop_clr) begin
          nDig = '{0, 0, 0, 0};
          nMode = 0;
        end else if (tick) begin
          nTicks = mTicksSeen + 1;
          if (nTicks == 3) begin
            nDig = '{0, 0, 0, 0};
            nTicks = 0;
            nMode = 0;
          end
        end
      end
      mMode <= nMode;
      mDig <= nDig;
      mTicksSeen <= nTicks;
      mLoadLow <= nLoad;
      mClearLow <= nClear;
    end
  end

  // Compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    checkOutput("state_o", 16'(state_o), 16'(mMode));
    checkOutput("timer_data", timer_data, packDigits(mDig));
    checkOutput("timer_loadn", 16'(timer_loadn), 16'(!mLoadLow));
    checkOutput("timer_clrn", 16'(timer_clrn), 16'(!mClearLow));
    checkOutput("timer_en", 16'(timer_en), 16'((mMode == 2) && tick && door_closed && !timer_zero));
    checkOutput("mag_on", 16'(mag_on), 16'((mMode == 2) && door_closed));
    checkOutput("beep", 16'(beep), 16'(mMode == 4));
    checkOutput("strobe_excl", 16'(timer_loadn | timer_clrn), 16'd1);
  end

  task automatic applyStimulus(input logic kv, input logic [3:0] kd, input logic st,
                               input logic sc, input logic dr, input logic tk, input logic tz);
    key_valid = kv;
    key_digit = kd;
    start = st;
    stop_clr = sc;
    door_closed = dr;
    tick = tk;
    timer_zero = tz;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    start = 1'b0;
    stop_clr = 1'b0;
    tick = 1'b0;
  endtask

  task automatic pressKey(input logic [3:0] kd);
    applyStimulus(1'b1, kd, 1'b0, 1'b0, door_closed, 1'b0, timer_zero);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, door_closed, 1'b0, timer_zero);
  endtask

  task automatic tickExpectEnable(input logic exp);
    tick = 1'b1;
    #1;
    checkOutput("tick_en_literal", 16'(timer_en), 16'(exp));
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  initial begin
    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", 16'(state_o), 16'd0);
    checkOutput("rst_data", timer_data, 16'h0000);
    checkOutput("rst_loadn", 16'(timer_loadn), 16'd1);
    checkOutput("rst_clrn", 16'(timer_clrn), 16'd1);
    checkOutput("rst_mag", 16'(mag_on), 16'd0);
    checkOutput("rst_beep", 16'(beep), 16'd0);
    clrn = 1'b1;
    idleCycles(1);

    $display("[TB] entry 1,3,0 and start");
    pressKey(4'd1);
    pressKey(4'd3);
    pressKey(4'd0);
    checkOutput("entry_130", timer_data, 16'h0130);
    checkOutput("entry_state", 16'(state_o), 16'd1);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("start_state", 16'(state_o), 16'd2);
    checkOutput("start_loadn", 16'(timer_loadn), 16'd0);
    checkOutput("start_mag", 16'(mag_on), 16'd1);
    idleCycles(1);
    checkOutput("loadn_one_cycle", 16'(timer_loadn), 16'd1);
    for (int i = 0; i < 3; i++) tickExpectEnable(1'b1);

    $display("[TB] door open and resume");
    door_closed = 1'b0;
    #1;
    checkOutput("door_mag_drop", 16'(mag_on), 16'd0);
    @(posedge clk);
    #1;
    checkOutput("door_pause", 16'(state_o), 16'd3);
    tickExpectEnable(1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("resume_state", 16'(state_o), 16'd2);
    checkOutput("resume_no_load", 16'(timer_loadn), 16'd1);
    checkOutput("resume_data", timer_data, 16'h0130);

    $display("[TB] completion");
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("done_state", 16'(state_o), 16'd4);
    checkOutput("done_beep", 16'(beep), 16'd1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("done_after2", 16'(state_o), 16'd4);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("done_exit_state", 16'(state_o), 16'd0);
    checkOutput("done_exit_beep", 16'(beep), 16'd0);
    checkOutput("done_exit_data", timer_data, 16'h0000);

    $display("[TB] five keys and invalid key");
    for (int k = 1; k <= 5; k++) pressKey(4'(k));
    checkOutput("five_keys", timer_data, 16'h2345);
    pressKey(4'd12);
    checkOutput("key_12_ignored", timer_data, 16'h2345);

    $display("[TB] refused starts and clear");
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("start_door_open", 16'(state_o), 16'd1);
    checkOutput("start_door_loadn", 16'(timer_loadn), 16'd1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("entry_clear_state", 16'(state_o), 16'd0);
    checkOutput("entry_clear_clrn", 16'(timer_clrn), 16'd0);
    checkOutput("entry_clear_data", timer_data, 16'h0000);
    pressKey(4'd0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("start_zero_entry", 16'(state_o), 16'd1);
    checkOutput("start_zero_loadn", 16'(timer_loadn), 16'd1);

    $display("[TB] masked timer_zero, pause, start+stop");
    pressKey(4'd7);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("zero_during_load", 16'(state_o), 16'd2);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("stop_pause", 16'(state_o), 16'd3);
    checkOutput("stop_pause_data", timer_data, 16'h0007);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("both_state", 16'(state_o), 16'd0);
    checkOutput("both_clrn", 16'(timer_clrn), 16'd0);
    checkOutput("both_loadn", 16'(timer_loadn), 16'd1);
    idleCycles(1);
    checkOutput("clrn_one_cycle", 16'(timer_clrn), 16'd1);

    $display("[TB] stop in DONE");
    pressKey(4'd9);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("done2_state", 16'(state_o), 16'd4);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("done_stop_state", 16'(state_o), 16'd0);

    $display("[TB] reset during cook");
    pressKey(4'd5);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(2);
    checkOutput("cook_before_rst", 16'(mag_on), 16'd1);
    clrn = 1'b0;
    #1;
    checkOutput("rst_mid_mag", 16'(mag_on), 16'd0);
    checkOutput("rst_mid_state", 16'(state_o), 16'd0);
    checkOutput("rst_mid_data", timer_data, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    idleCycles(3);
    checkOutput("post_rst_state", 16'(state_o), 16'd0);
    checkOutput("post_rst_loadn", 16'(timer_loadn), 16'd1);
    checkOutput("post_rst_clrn", 16'(timer_clrn), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
